// File: rtl/ctrl_pkg.sv
// ctrl_pkg: encodings shared by the control FSM and the ALU.
package ctrl_pkg;
  typedef enum logic [3:0] {
    ALU_ADD = 4'h0, ALU_SUB = 4'h1, ALU_SLL = 4'h2, ALU_SLT = 4'h3,
    ALU_SLTU = 4'h4, ALU_XOR = 4'h5, ALU_SRL = 4'h6, ALU_SRA = 4'h7,
    ALU_OR = 4'h8, ALU_AND = 4'h9, ALU_LUI = 4'hA, ALU_AUIPC = 4'hB
  } alu_op_e;
  typedef enum logic [2:0] {
    S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2, S_MEM = 3'd3, S_WB = 3'd4, S_TRAP = 3'd5
  } state_e;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [1:0] PC_PLUS4 = 2'd0, PC_BRANCH = 2'd1, PC_ALU = 2'd2;
  localparam logic [1:0] WB_ALU = 2'd0, WB_MEM = 2'd1, WB_PC4 = 2'd2;
  function automatic logic opc_known(input logic [6:0] opc);
    return opc inside {OPC_OP, OPC_OPIMM, OPC_LOAD, OPC_STORE, OPC_BRANCH,
                       OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR};
  endfunction
endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: maps opcode/funct3/funct7 to the ALU operation.
module alu_decoder
  import ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output alu_op_e    alu_op
);
  logic    unused;
  alu_op_e arith;
  assign unused = ^{funct7[6], funct7[4:0]};
  always_comb begin
    arith = ALU_ADD;
    case (funct3)
      3'b000: arith = (opcode == OPC_OP && funct7[5]) ? ALU_SUB : ALU_ADD;
      3'b001: arith = ALU_SLL;
      3'b010: arith = ALU_SLT;
      3'b011: arith = ALU_SLTU;
      3'b100: arith = ALU_XOR;
      3'b101: arith = funct7[5] ? ALU_SRA : ALU_SRL;
      3'b110: arith = ALU_OR;
      default: arith = ALU_AND;
    endcase
  end
  // OP-IMM only looks at funct7 for the shift-right form, where it is imm[10]
  assign alu_op = (opcode == OPC_OP || opcode == OPC_OPIMM) ? arith :
                  opcode == OPC_BRANCH ? ALU_SUB :
                  opcode == OPC_LUI    ? ALU_LUI :
                  opcode == OPC_AUIPC  ? ALU_AUIPC : ALU_ADD;
endmodule

// File: rtl/control_fsm.sv
// control_fsm: multi-cycle RV32I control FSM with memory wait timeout.
// Define CTRL_TRAP_EN to trap on unrecognised opcodes instead of treating them as NOPs.
module control_fsm
  import ctrl_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        mem_ready,
  input  logic        alu_zero,
  input  logic        alu_less_than,
  input  logic        alu_less_than_u,
  output logic [3:0]  alu_op,
  output logic        alu_src_a,
  output logic        alu_src_b,
  output logic        ir_we,
  output logic        pc_we,
  output logic        mem_re,
  output logic        mem_we,
  output logic        reg_we,
  output logic [1:0]  pc_sel,
  output logic [1:0]  wb_sel,
  output logic [2:0]  mem_funct3,
  output logic [2:0]  state,
  output logic        trap
);
  localparam int CW = $clog2(MEM_WAIT_MAX + 1);
  state_e      cur, nxt;
  logic [CW-1:0] wait_cnt;
  logic [31:0] ir;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  alu_op_e     dec_op;
  logic        is_load, is_store, is_branch, is_jump, known, taken, timeout, unused;
  assign opcode     = ir[6:0];
  assign funct3     = ir[14:12];
  assign unused     = ^{ir[24:15], ir[11:7]};
  assign is_load    = opcode == OPC_LOAD;
  assign is_store   = opcode == OPC_STORE;
  assign is_branch  = opcode == OPC_BRANCH;
  assign is_jump    = opcode == OPC_JAL || opcode == OPC_JALR;
  assign known      = opc_known(opcode);
  assign timeout    = !mem_ready && wait_cnt == CW'(MEM_WAIT_MAX - 1);
  assign mem_funct3 = funct3;
  assign state      = cur;
  assign taken = funct3 == 3'b000 ? alu_zero :
                 funct3 == 3'b001 ? !alu_zero :
                 funct3 == 3'b100 ? alu_less_than :
                 funct3 == 3'b101 ? !alu_less_than :
                 funct3 == 3'b110 ? alu_less_than_u :
                 funct3 == 3'b111 ? !alu_less_than_u : 1'b0;
  alu_decoder u_dec (
    .opcode(opcode),
    .funct3(funct3),
    .funct7(ir[31:25]),
    .alu_op(dec_op)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur      <= S_FETCH;
      wait_cnt <= '0;
      ir       <= '0;
    end else begin
      cur      <= nxt;
      wait_cnt <= (nxt != cur || cur == S_TRAP) ? '0 : wait_cnt + 1'b1;
      if (cur == S_FETCH && mem_ready) ir <= instr;
    end
  end
  always_comb begin
    nxt = cur;
    case (cur)
      S_FETCH:  nxt = mem_ready ? S_DECODE : timeout ? S_TRAP : S_FETCH;
`ifdef CTRL_TRAP_EN
      S_DECODE: nxt = known ? S_EXEC : S_TRAP;
`else
      S_DECODE: nxt = S_EXEC;
`endif
      S_EXEC:   nxt = (is_load || is_store) ? S_MEM : is_branch ? S_FETCH : S_WB;
      S_MEM:    nxt = mem_ready ? (is_load ? S_WB : S_FETCH) : timeout ? S_TRAP : S_MEM;
      S_WB:     nxt = S_FETCH;
      S_TRAP:   nxt = S_TRAP;
      default:  nxt = S_FETCH;
    endcase
  end
  // Outputs are forced low while reset is held so FETCH does not raise mem_re early
  always_comb begin
    alu_op    = 4'h0;
    alu_src_a = 1'b0;
    alu_src_b = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    reg_we    = 1'b0;
    pc_sel    = PC_PLUS4;
    wb_sel    = WB_ALU;
    trap      = 1'b0;
    if (rst_n) begin
      case (cur)
        S_FETCH: begin
          mem_re = 1'b1;
          ir_we  = mem_ready;
        end
        S_EXEC: begin
          pc_we  = is_branch;
          pc_sel = (is_branch && taken) ? PC_BRANCH : PC_PLUS4;
        end
        S_MEM: begin
          mem_re = is_load;
          mem_we = is_store;
          pc_we  = is_store && mem_ready;
        end
        S_WB: begin
          reg_we = known;
          pc_we  = 1'b1;
          pc_sel = is_jump ? PC_ALU : PC_PLUS4;
          wb_sel = is_jump ? WB_PC4 : is_load ? WB_MEM : WB_ALU;
        end
        S_TRAP:  trap = 1'b1;
        default: ;
      endcase
      if (cur inside {S_EXEC, S_MEM, S_WB}) begin
        alu_op    = dec_op;
        alu_src_a = opcode == OPC_AUIPC || opcode == OPC_JAL;
        alu_src_b = !(opcode == OPC_OP || is_branch);
      end
    end
  end
endmodule

// File: doc/control_fsm.md
CONTROL_FSM -- requirements
Module: control_fsm

Interface
REQ-001 SHALL have parameter MEM_WAIT_MAX, default 15, meaning the maximum cycles spent waiting for mem_ready in one state.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst_n  input  1  reset: synchronous, active-low.
REQ-004 SHALL have port instr  input  32  fetched instruction word, valid while mem_ready is high in FETCH.
REQ-005 SHALL have port mem_ready  input  1  memory handshake: read data is valid, or the write is accepted.
REQ-006 SHALL have ports alu_zero, alu_less_than, alu_less_than_u  input  1 each  ALU flags, combinational from the current operands.
REQ-007 SHALL have port alu_op  output  4  ALU operation; encoding ADD=0 SUB=1 SLL=2 SLT=3 SLTU=4 XOR=5 SRL=6 SRA=7 OR=8 AND=9 LUI=A AUIPC=B.
REQ-008 SHALL have ports alu_src_a  output  1  (0=rs1, 1=PC) and alu_src_b  output  1  (0=rs2, 1=imm).
REQ-009 SHALL have ports ir_we, pc_we, mem_re, mem_we, reg_we  output  1 each  enables.
REQ-010 SHALL have port pc_sel  output  2  next-PC source: 0=PC+4, 1=branch target, 2=ALU result (JAL/JALR).
REQ-011 SHALL have port wb_sel  output  2  writeback source: 0=ALU result, 1=memory data, 2=PC+4.
REQ-012 SHALL have ports mem_funct3  output  3  (latched funct3 for load/store width), state  output  3  (current state), trap  output  1.

Function
REQ-013 SHALL latch instr internally on the FETCH cycle where mem_ready=1, asserting ir_we for exactly that cycle.
REQ-014 SHALL implement states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5.
REQ-015 FETCH SHALL assert mem_re, remain in FETCH while mem_ready=0, and go to DECODE on mem_ready=1.
REQ-016 DECODE SHALL last exactly one cycle and then go to EXEC.
REQ-017 From EXEC, next state SHALL be: MEM for load/store; FETCH for branches; WB otherwise.
REQ-018 Sequences SHALL be: OP/OP-IMM/LUI/AUIPC/JAL/JALR = F,D,E,WB; load = F,D,E,M,WB; store = F,D,E,M; branch = F,D,E (not counting memory wait cycles).
REQ-019 EXEC alu_op SHALL be:
 - OP: from funct3/funct7[5] (SUB, SRA when funct7[5]=1).
 - OP-IMM: from funct3; SRAI when imm[10]=1; funct7 is ignored otherwise.
 - load, store, JAL, JALR: ADD.
 - branch: SUB.
 - LUI: LUI.
 - AUIPC: AUIPC.
REQ-020 Branch taken SHALL be decided in EXEC: BEQ=zero, BNE=!zero, BLT=lt, BGE=!lt, BLTU=ltu, BGEU=!ltu. pc_we=1 in EXEC, with pc_sel=1 if taken, else 0.
REQ-021 MEM SHALL assert mem_re (load) or mem_we (store) and hold while mem_ready=0. On mem_ready=1: a load goes to WB; a store asserts pc_we with pc_sel=0 and goes to FETCH.
REQ-022 WB SHALL assert reg_we and pc_we for one cycle, then go to FETCH.
 - pc_sel=2 for JAL/JALR, else 0.
 - wb_sel=2 for JAL/JALR, 1 for loads, else 0.
REQ-023 A per-state wait counter SHALL clear on every state change. If mem_ready stays 0 for MEM_WAIT_MAX consecutive cycles, the FSM SHALL go to TRAP.
REQ-024 All enables SHALL be 0 in any state or cycle not listed above; at most one of mem_re and mem_we SHALL be 1 in any cycle.
REQ-025 TRAP SHALL hold trap=1 with all enables 0 until reset.

Reset
REQ-026 On a clk edge with rst_n=0, from any state including mid-wait, the FSM SHALL go to FETCH, clear the wait counter, latched instr and trap, and drive all enables, alu_op, pc_sel and wb_sel to 0.

Configuration
REQ-027 With CTRL_TRAP_EN defined, an unrecognised opcode in DECODE SHALL go to TRAP. Without it, such an opcode SHALL act as a NOP: WB with reg_we=0, pc_we=1 and pc_sel=0. The timeout trap in REQ-023 applies in both builds.

Structure
REQ-028 The alu_op encodings, state enum, opcode constants, pc_sel and wb_sel encodings SHALL live in package ctrl_pkg, shared with the ALU.
REQ-029 Sub-module alu_decoder (combinational, from opcode/funct3/funct7 to alu_op) SHALL be instantiated once.

Verification
REQ-030 ADD x1,x2,x3 (0x003100B3), mem_ready=1 -> states 0,1,2,4,0; alu_op=0 in EXEC; reg_we=1 and pc_we=1 in WB with pc_sel=0 and wb_sel=0.
REQ-031 BEQ with alu_zero=1 -> alu_op=1 and pc_we=1 with pc_sel=1 in EXEC, then FETCH. With alu_zero=0 -> pc_sel=0.
REQ-032 LW with mem_ready low for 3 cycles in MEM -> mem_re=1 for 4 cycles, then WB with wb_sel=1.
REQ-033 SW with mem_ready never asserted -> TRAP after 15 cycles in MEM, trap=1 and mem_we=0 thereafter.
REQ-034 Opcode 0x00000000 -> TRAP when CTRL_TRAP_EN is defined; otherwise NOP with pc_we=1 and reg_we=0.
REQ-035 rst_n=0 asserted during a MEM wait -> FETCH on the next edge with all outputs 0 and trap=0.
